imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the RISC-V core. Accepts a raw 32-bit instruction plus a format code through a valid/ready handshake and returns the extended immediate, with a pass-through tag, one cycle later. Sits between decode and execute, and generalises the fixed 12-bit I-type sign extension to XLEN 32/64, all base formats, zero-extended CSR and shift operands, an error flag and a 2-entry skid buffer.

---
 rtl/imm_gen_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator that sits between decode and execute. It
// takes a raw instruction plus a format code and produces the extended
// immediate. The result goes into a 2-entry FIFO that acts as a skid buffer
// and is returned together with an opaque tag.
//
// Parameters:
//   XLEN   - immediate width, 32 or 64
//   TAG_W  - width of the pass-through sideband tag
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; flushes the FIFO
//   in_valid   request present
//   in_ready   block can accept a request (never depends on out_ready)
//   in_instr   raw 32-bit instruction word
//   in_fmt     0=I 1=S 2=B 3=U 4=J 5=Z 6=SHAMT 7=reserved
//   in_tag     sideband, returned unchanged
//   out_valid  head entry present
//   out_ready  consumer accepts the head entry
//   out_imm    extended immediate of the head entry
//   out_tag    tag of the head entry
//   out_err    head entry had an illegal format/operand
//
// Configuration macro:
//   IMM_GEN_ZIMM_EN - when defined, fmt 5 returns zext(instr[19:15]);
//                     when undefined, fmt 5 is treated as reserved.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_Z     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  logic [63:0]      wideImm;
  logic [XLEN-1:0]  newImm;
  logic             newErr;

  logic [XLEN-1:0]  immMem_q [2];
  logic [TAG_W-1:0] tagMem_q [2];
  logic             errMem_q [2];
  logic             wrPtr_q, wrPtr_d;
  logic             rdPtr_q, rdPtr_d;
  logic [1:0]       count_q, count_d;
  logic             readyEn_q;
  logic             push, pop;

  // Every format is built at 64 bits and then truncated to XLEN, which keeps
  // the extension logic identical for both widths and avoids zero-width
  // replications when XLEN is 32.
  always_comb begin
    wideImm = 64'd0;
    newErr  = 1'b0;
    case (in_fmt)
      FMT_I: wideImm = {{52{in_instr[31]}}, in_instr[31:20]};
      FMT_S: wideImm = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: wideImm = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: wideImm = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
      FMT_J: wideImm = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z: begin
`ifdef IMM_GEN_ZIMM_EN
        wideImm = {59'd0, in_instr[19:15]};
`else
        newErr  = 1'b1;
`endif
      end
      FMT_SHAMT: begin
        // RV32 only has 5-bit shift amounts; bit 25 set is an illegal shift.
        if (XLEN == 64) begin
          wideImm = {58'd0, in_instr[25:20]};
        end else begin
          wideImm = {59'd0, in_instr[24:20]};
          newErr  = in_instr[25];
        end
      end
      default: newErr = 1'b1;
    endcase
  end

  assign newImm = wideImm[XLEN-1:0];

  // in_ready only looks at registered state, so there is no combinational
  // path from out_ready. readyEn_q holds it low until the first clock after
  // reset is released.
  assign in_ready  = readyEn_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // An empty FIFO presents all-zero outputs so stale entries never leak.
  assign out_imm = out_valid ? immMem_q[rdPtr_q] : '0;
  assign out_tag = out_valid ? tagMem_q[rdPtr_q] : '0;
  assign out_err = out_valid ? errMem_q[rdPtr_q] : 1'b0;

  // Pointer and occupancy bookkeeping; push and pop together leave the
  // count unchanged while both pointers advance.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = ~wrPtr_q;
    if (pop)  rdPtr_d = ~rdPtr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State and storage registers; reset discards any in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      count_q     <= 2'd0;
      readyEn_q   <= 1'b0;
      immMem_q[0] <= '0;
      immMem_q[1] <= '0;
      tagMem_q[0] <= '0;
      tagMem_q[1] <= '0;
      errMem_q[0] <= 1'b0;
      errMem_q[1] <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      readyEn_q <= 1'b1;
      if (push) begin
        immMem_q[wrPtr_q] <= newImm;
        tagMem_q[wrPtr_q] <= in_tag;
        errMem_q[wrPtr_q] <= newErr;
      end
    end
  end

endmodule
